// File: rtl/sram_frame_scheduler.sv
//------------------------------------------------------------------------------
// Module      : sram_frame_scheduler
// Description : Grants exclusive full-frame write/read phases to the SRAM image
//               controller and drives its reset and configuration. The optional
//               phase watchdog is enabled by defining SRAM_SCHED_TIMEOUT_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sram_frame_scheduler #(
    parameter int ADDR_W         = 13,
    parameter int SIZE_W         = 23,
    parameter int LOAD_CYCLES    = 2,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic [SIZE_W-1:0] cfg_image_size_i,
    input  logic [ADDR_W-1:0] cfg_base_addr_i,
    input  logic              cfg_update_i,
    input  logic              wr_req_i,
    input  logic              wr_done_i,
    input  logic              rd_req_i,
    input  logic              rd_done_i,
    output logic              wr_grant_o,
    output logic              rd_grant_o,
    output logic              ctrl_reset_n_o,
    output logic [ADDR_W-1:0] ctrl_start_addr_o,
    output logic [SIZE_W-1:0] ctrl_image_size_o,
    output logic              frame_ready_o,
    output logic              busy_o,
    output logic [15:0]       drop_count_o,
    output logic              timeout_flag_o
);

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_IDLE  = 3'd1,
        S_WRITE = 3'd2,
        S_WGAP  = 3'd3,
        S_READ  = 3'd4,
        S_RGAP  = 3'd5
    } state_t;

    localparam int                LCNT_W    = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam logic [LCNT_W-1:0] LOAD_LAST = LCNT_W'(LOAD_CYCLES - 1);
    localparam logic [LCNT_W-1:0] LCNT_ONE  = LCNT_W'(1);

    state_t              state_q;
    logic [LCNT_W-1:0]   load_cnt_q;
    logic                ctrl_reset_n_q;
    logic [ADDR_W-1:0]   start_addr_q;
    logic [SIZE_W-1:0]   image_size_q;
    logic                wr_grant_q;
    logic                rd_grant_q;
    logic                frame_ready_q;
    logic [15:0]         drop_count_q;
    logic [15:0]         drop_count_d;
    logic                wr_drop;
    logic                wr_abort;
    logic                rd_abort;
    logic                cfg_accept;

    // A write request is only accepted from idle with no frame pending and no reload.
    always_comb begin
        wr_drop = 1'b0;
        if (wr_req_i) begin
            if (state_q != S_IDLE) begin
                wr_drop = 1'b1;
            end else if (cfg_update_i || frame_ready_q) begin
                wr_drop = 1'b1;
            end
        end
    end

    assign cfg_accept = (state_q == S_IDLE) && cfg_update_i;

    always_comb begin
        drop_count_d = drop_count_q;
        if (wr_drop && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            drop_count_q <= 16'd0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

`ifdef SRAM_SCHED_TIMEOUT_EN
    logic [31:0] phase_cnt_q;
    logic        timeout_flag_q;
    logic        phase_expired;

    assign phase_expired = (phase_cnt_q == 32'(TIMEOUT_CYCLES - 1));
    assign wr_abort      = (state_q == S_WRITE) && !wr_done_i && phase_expired;
    assign rd_abort      = (state_q == S_READ)  && !rd_done_i && phase_expired;

    // Every phase is entered from idle, so the counter is already clear on entry.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            phase_cnt_q <= 32'd0;
        end else if ((state_q == S_WRITE) || (state_q == S_READ)) begin
            phase_cnt_q <= phase_cnt_q + 32'd1;
        end else begin
            phase_cnt_q <= 32'd0;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            timeout_flag_q <= 1'b0;
        end else if (cfg_accept) begin
            timeout_flag_q <= 1'b0;
        end else if (wr_abort || rd_abort) begin
            timeout_flag_q <= 1'b1;
        end
    end

    assign timeout_flag_o = timeout_flag_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign wr_abort           = 1'b0;
    assign rd_abort           = 1'b0;
    assign timeout_flag_o     = 1'b0;
`endif

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q        <= S_LOAD;
            load_cnt_q     <= '0;
            ctrl_reset_n_q <= 1'b0;
            start_addr_q   <= '0;
            image_size_q   <= '0;
            wr_grant_q     <= 1'b0;
            rd_grant_q     <= 1'b0;
            frame_ready_q  <= 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (load_cnt_q == '0) begin
                        start_addr_q <= cfg_base_addr_i;
                        image_size_q <= cfg_image_size_i;
                    end
                    if (load_cnt_q == LOAD_LAST) begin
                        load_cnt_q     <= '0;
                        ctrl_reset_n_q <= 1'b1;
                        state_q        <= S_IDLE;
                    end else begin
                        load_cnt_q <= load_cnt_q + LCNT_ONE;
                    end
                end
                S_IDLE: begin
                    if (cfg_update_i) begin
                        frame_ready_q  <= 1'b0;
                        ctrl_reset_n_q <= 1'b0;
                        load_cnt_q     <= '0;
                        state_q        <= S_LOAD;
                    end else if (rd_req_i && frame_ready_q) begin
                        rd_grant_q <= 1'b1;
                        state_q    <= S_READ;
                    end else if (wr_req_i && !frame_ready_q) begin
                        wr_grant_q <= 1'b1;
                        state_q    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (wr_done_i) begin
                        wr_grant_q    <= 1'b0;
                        frame_ready_q <= 1'b1;
                        state_q       <= S_WGAP;
                    end else if (wr_abort) begin
                        // A partially written frame is useless; re-reset the controller.
                        wr_grant_q     <= 1'b0;
                        frame_ready_q  <= 1'b0;
                        ctrl_reset_n_q <= 1'b0;
                        load_cnt_q     <= '0;
                        state_q        <= S_LOAD;
                    end
                end
                S_READ: begin
                    if (rd_done_i) begin
                        rd_grant_q    <= 1'b0;
                        frame_ready_q <= 1'b0;
                        state_q       <= S_RGAP;
                    end else if (rd_abort) begin
                        rd_grant_q     <= 1'b0;
                        frame_ready_q  <= 1'b0;
                        ctrl_reset_n_q <= 1'b0;
                        load_cnt_q     <= '0;
                        state_q        <= S_LOAD;
                    end
                end
                S_WGAP: begin
                    state_q <= S_IDLE;
                end
                S_RGAP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    wr_grant_q     <= 1'b0;
                    rd_grant_q     <= 1'b0;
                    ctrl_reset_n_q <= 1'b0;
                    load_cnt_q     <= '0;
                    state_q        <= S_LOAD;
                end
            endcase
        end
    end

    assign wr_grant_o        = wr_grant_q;
    assign rd_grant_o        = rd_grant_q;
    assign ctrl_reset_n_o    = ctrl_reset_n_q;
    assign ctrl_start_addr_o = start_addr_q;
    assign ctrl_image_size_o = image_size_q;
    assign frame_ready_o     = frame_ready_q;
    assign busy_o            = (state_q != S_IDLE);
    assign drop_count_o      = drop_count_q;

    a_grants_exclusive : assert property (@(posedge clock_i) disable iff (reset_i)
        !(wr_grant_q && rd_grant_q));

    a_no_wr_regrant : assert property (@(posedge clock_i) disable iff (reset_i)
        ($fell(wr_grant_q) |=> !wr_grant_q));

    a_no_rd_regrant : assert property (@(posedge clock_i) disable iff (reset_i)
        ($fell(rd_grant_q) |=> !rd_grant_q));

endmodule

`default_nettype wire

// File: tb/tb_sram_frame_scheduler.sv
//------------------------------------------------------------------------------
// Module      : tb_sram_frame_scheduler
// Description : Directed self-checking bench for sram_frame_scheduler.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sram_frame_scheduler;

    localparam int ADDR_W      = 13;
    localparam int SIZE_W      = 23;
    localparam int LOAD_CYCLES = 2;
`ifdef SRAM_SCHED_TIMEOUT_EN
    localparam int TIMEOUT_CYCLES = 16;
`else
    localparam int TIMEOUT_CYCLES = 1048576;
`endif

    logic              clk;
    logic              rst;
    logic [SIZE_W-1:0] cfg_image_size;
    logic [ADDR_W-1:0] cfg_base_addr;
    logic              cfg_update;
    logic              wr_req;
    logic              wr_done;
    logic              rd_req;
    logic              rd_done;
    logic              wr_grant;
    logic              rd_grant;
    logic              ctrl_reset_n;
    logic [ADDR_W-1:0] ctrl_start_addr;
    logic [SIZE_W-1:0] ctrl_image_size;
    logic              frame_ready;
    logic              busy;
    logic [15:0]       drop_count;
    logic              timeout_flag;

    int chk_cnt;
    int fail_cnt;

    sram_frame_scheduler #(
        .ADDR_W         (ADDR_W),
        .SIZE_W         (SIZE_W),
        .LOAD_CYCLES    (LOAD_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_dut (
        .clock_i           (clk),
        .reset_i           (rst),
        .cfg_image_size_i  (cfg_image_size),
        .cfg_base_addr_i   (cfg_base_addr),
        .cfg_update_i      (cfg_update),
        .wr_req_i          (wr_req),
        .wr_done_i         (wr_done),
        .rd_req_i          (rd_req),
        .rd_done_i         (rd_done),
        .wr_grant_o        (wr_grant),
        .rd_grant_o        (rd_grant),
        .ctrl_reset_n_o    (ctrl_reset_n),
        .ctrl_start_addr_o (ctrl_start_addr),
        .ctrl_image_size_o (ctrl_image_size),
        .frame_ready_o     (frame_ready),
        .busy_o            (busy),
        .drop_count_o      (drop_count),
        .timeout_flag_o    (timeout_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt = chk_cnt + 1;
        if (got !== exp) begin
            fail_cnt = fail_cnt + 1;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after an edge and are sampled by the next one.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        chk_cnt        = 0;
        fail_cnt       = 0;
        rst            = 1'b1;
        cfg_image_size = 23'h800;
        cfg_base_addr  = 13'h100;
        cfg_update     = 1'b0;
        wr_req         = 1'b0;
        wr_done        = 1'b0;
        rd_req         = 1'b0;
        rd_done        = 1'b0;
        step();
        step();

        // T1: reset state and configuration load
        check_eq("rst_ctrl_reset_n", {31'd0, ctrl_reset_n}, 32'd0);
        check_eq("rst_wr_grant", {31'd0, wr_grant}, 32'd0);
        check_eq("rst_rd_grant", {31'd0, rd_grant}, 32'd0);
        check_eq("rst_start_addr", {19'd0, ctrl_start_addr}, 32'd0);
        check_eq("rst_image_size", {9'd0, ctrl_image_size}, 32'd0);
        check_eq("rst_frame_ready", {31'd0, frame_ready}, 32'd0);
        check_eq("rst_drop_count", {16'd0, drop_count}, 32'd0);
        check_eq("rst_timeout", {31'd0, timeout_flag}, 32'd0);
        rst = 1'b0;
        step();
        check_eq("load1_reset_n", {31'd0, ctrl_reset_n}, 32'd0);
        check_eq("load1_start_addr", {19'd0, ctrl_start_addr}, 32'h100);
        check_eq("load1_busy", {31'd0, busy}, 32'd1);
        cfg_base_addr = 13'h1FF;
        step();
        check_eq("load2_reset_n", {31'd0, ctrl_reset_n}, 32'd1);
        check_eq("load2_image_size", {9'd0, ctrl_image_size}, 32'h800);
        check_eq("idle_busy", {31'd0, busy}, 32'd0);
        step();
        check_eq("cfg_held_addr", {19'd0, ctrl_start_addr}, 32'h100);

        // T2: write phase, foreign done ignored
        wr_req = 1'b1;
        step();
        wr_req = 1'b0;
        check_eq("t2_wr_grant_rise", {31'd0, wr_grant}, 32'd1);
        check_eq("t2_busy", {31'd0, busy}, 32'd1);
        rd_done = 1'b1;
        step();
        rd_done = 1'b0;
        check_eq("t2_rd_done_ignored", {31'd0, wr_grant}, 32'd1);
        check_eq("t2_fr_still_0", {31'd0, frame_ready}, 32'd0);
        wr_done = 1'b1;
        step();
        wr_done = 1'b0;
        check_eq("t2_wr_grant_fall", {31'd0, wr_grant}, 32'd0);
        check_eq("t2_frame_ready", {31'd0, frame_ready}, 32'd1);
        check_eq("t2_busy_wgap", {31'd0, busy}, 32'd1);
        step();
        check_eq("t2_busy_low", {31'd0, busy}, 32'd0);

        // T3: simultaneous requests with a stored frame -> read wins
        wr_req = 1'b1;
        rd_req = 1'b1;
        step();
        wr_req = 1'b0;
        rd_req = 1'b0;
        check_eq("t3_rd_grant", {31'd0, rd_grant}, 32'd1);
        check_eq("t3_wr_grant", {31'd0, wr_grant}, 32'd0);
        check_eq("t3_drop", {16'd0, drop_count}, 32'd1);
        rd_done = 1'b1;
        step();
        rd_done = 1'b0;
        check_eq("t3_rd_grant_fall", {31'd0, rd_grant}, 32'd0);
        check_eq("t3_frame_cleared", {31'd0, frame_ready}, 32'd0);
        step();
        wr_done = 1'b1;
        step();
        wr_done = 1'b0;
        check_eq("idle_wr_done_ignored", {31'd0, frame_ready}, 32'd0);
        check_eq("idle_wr_done_busy", {31'd0, busy}, 32'd0);

        // T4: pending read waits for a frame to be written
        rd_req = 1'b1;
        repeat (3) step();
        check_eq("t4_no_rd_grant", {31'd0, rd_grant}, 32'd0);
        check_eq("t4_idle", {31'd0, busy}, 32'd0);
        wr_req = 1'b1;
        step();
        wr_req = 1'b0;
        check_eq("t4_wr_grant", {31'd0, wr_grant}, 32'd1);
        wr_done = 1'b1;
        step();
        wr_done = 1'b0;
        check_eq("t4_wgap_fr", {31'd0, frame_ready}, 32'd1);
        check_eq("t4_wgap_rd", {31'd0, rd_grant}, 32'd0);
        step();
        check_eq("t4_idle_rd", {31'd0, rd_grant}, 32'd0);
        step();
        rd_req = 1'b0;
        check_eq("t4_rd_grant", {31'd0, rd_grant}, 32'd1);
        wr_req = 1'b1;
        step();
        wr_req = 1'b0;
        check_eq("t4_drop_in_read", {16'd0, drop_count}, 32'd2);
        check_eq("t4_wr_grant_in_read", {31'd0, wr_grant}, 32'd0);
        rd_done = 1'b1;
        step();
        rd_done = 1'b0;
        check_eq("t4_rd_fall", {31'd0, rd_grant}, 32'd0);
        check_eq("t4_fr_cleared", {31'd0, frame_ready}, 32'd0);
        step();

        // wr_req in idle with a stored frame is dropped
        wr_req = 1'b1;
        step();
        wr_req  = 1'b0;
        wr_done = 1'b1;
        step();
        wr_done = 1'b0;
        step();
        check_eq("fr_set_again", {31'd0, frame_ready}, 32'd1);
        wr_req = 1'b1;
        step();
        wr_req = 1'b0;
        check_eq("idle_fr_drop", {16'd0, drop_count}, 32'd3);
        check_eq("idle_fr_no_grant", {31'd0, wr_grant}, 32'd0);

        // cfg_update beats a simultaneous wr_req and reloads configuration
        cfg_base_addr  = 13'h0ABC;
        cfg_image_size = 23'h1234;
        cfg_update     = 1'b1;
        wr_req         = 1'b1;
        step();
        cfg_update = 1'b0;
        wr_req     = 1'b0;
        check_eq("cfg_drop", {16'd0, drop_count}, 32'd4);
        check_eq("cfg_reset_n_low", {31'd0, ctrl_reset_n}, 32'd0);
        check_eq("cfg_fr_cleared", {31'd0, frame_ready}, 32'd0);
        check_eq("cfg_wr_grant", {31'd0, wr_grant}, 32'd0);
        step();
        check_eq("cfg_addr", {19'd0, ctrl_start_addr}, 32'hABC);
        check_eq("cfg_reset_n_low2", {31'd0, ctrl_reset_n}, 32'd0);
        step();
        check_eq("cfg_size", {9'd0, ctrl_image_size}, 32'h1234);
        check_eq("cfg_reset_n_high", {31'd0, ctrl_reset_n}, 32'd1);

        // T5: drop counter saturation during a long write, then reset mid-phase
        wr_req = 1'b1;
        step();
        check_eq("t5_accept", {31'd0, wr_grant}, 32'd1);
        check_eq("t5_drop_start", {16'd0, drop_count}, 32'd4);
        repeat (10) step();
        check_eq("t5_drop_10", {16'd0, drop_count}, 32'd14);
        repeat (32'h10005 - 10) step();
        wr_req = 1'b0;
        check_eq("t5_drop_sat", {16'd0, drop_count}, 32'hFFFF);
        check_eq("t5_still_writing", {31'd0, wr_grant}, 32'd1);
        rst = 1'b1;
        step();
        check_eq("midrst_wr_grant", {31'd0, wr_grant}, 32'd0);
        check_eq("midrst_fr", {31'd0, frame_ready}, 32'd0);
        check_eq("midrst_drop", {16'd0, drop_count}, 32'd0);
        check_eq("midrst_reset_n", {31'd0, ctrl_reset_n}, 32'd0);
        rst = 1'b0;
        step();
        step();
        check_eq("midrst_reload", {31'd0, ctrl_reset_n}, 32'd1);
        check_eq("midrst_addr", {19'd0, ctrl_start_addr}, 32'hABC);

`ifdef SRAM_SCHED_TIMEOUT_EN
        // T6: watchdog aborts a write that never completes
        wr_req = 1'b1;
        step();
        wr_req = 1'b0;
        n = 0;
        while (wr_grant && n < 40) begin
            n = n + 1;
            step();
        end
        check_eq("t6_grant_cycles", n, 32'd16);
        check_eq("t6_timeout_flag", {31'd0, timeout_flag}, 32'd1);
        check_eq("t6_fr", {31'd0, frame_ready}, 32'd0);
        check_eq("t6_reset_n_low1", {31'd0, ctrl_reset_n}, 32'd0);
        step();
        check_eq("t6_reset_n_low2", {31'd0, ctrl_reset_n}, 32'd0);
        step();
        check_eq("t6_reset_n_high", {31'd0, ctrl_reset_n}, 32'd1);
        check_eq("t6_flag_sticky", {31'd0, timeout_flag}, 32'd1);
        cfg_update = 1'b1;
        step();
        cfg_update = 1'b0;
        check_eq("t6_flag_cleared", {31'd0, timeout_flag}, 32'd0);
        step();
        step();
`else
        n = 0;
        wr_req = 1'b1;
        step();
        wr_req = 1'b0;
        repeat (40) begin
            if (wr_grant) n = n + 1;
            step();
        end
        check_eq("no_wdog_grant_held", n, 32'd40);
        check_eq("no_wdog_flag", {31'd0, timeout_flag}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, fail_cnt);
        $finish;
    end

endmodule

`default_nettype wire
